// File: rtl/cdr.sv
//------------------------------------------------------------------------------
// Module   : cdr
// Brief    : Scan-testable core data register: counter plus signature register,
//            stitched into one serial chain {sig, cnt} for wrapper load/unload.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdr #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
    input  logic CLK,
    input  logic CoreIN_RESET,
    input  logic se,
    input  logic ScanChainIN,
    output logic ScanChainOut
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] sig;
    logic             fb;

    assign fb = ^(sig & TAPS);

    // Shift mode treats {sig, cnt} as one register; functional mode compacts
    // the pre-edge count into the signature.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            cnt <= '0;
            sig <= '0;
        end else if (se) begin
            cnt <= {cnt[WIDTH-2:0], ScanChainIN};
            sig <= {sig[WIDTH-2:0], cnt[WIDTH-1]};
        end else begin
            cnt <= cnt + ONE;
            sig <= {sig[WIDTH-2:0], fb} ^ cnt;
        end
    end

    assign ScanChainOut = sig[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_cdr.sv
//------------------------------------------------------------------------------
// Module   : tb_cdr
// Brief    : Directed self-checking bench for cdr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdr;

    logic CLK = 1'b0;
    logic CoreIN_RESET = 1'b0;
    logic se = 1'b0;
    logic ScanChainIN = 1'b0;
    logic ScanChainOut;

    int total = 0;
    int bad = 0;

    cdr #(.WIDTH(8), .TAPS(8'hB8)) dut (
        .CLK          (CLK),
        .CoreIN_RESET (CoreIN_RESET),
        .se           (se),
        .ScanChainIN  (ScanChainIN),
        .ScanChainOut (ScanChainOut)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] unload_exp;
    logic [15:0] load_val;
    logic [7:0]  sig_steps [4];
    logic        exp_bit;

    initial begin
        sig_steps[0] = 8'h00; sig_steps[1] = 8'h01;
        sig_steps[2] = 8'h00; sig_steps[3] = 8'h03;

        // Initial asynchronous reset between edges
        #2 CoreIN_RESET = 1'b1;
        #1;
        check("reset_out", {15'd0, ScanChainOut}, 16'd0);
        check("reset_state", {dut.sig, dut.cnt}, 16'h0000);
        tick();
        CoreIN_RESET = 1'b0;

        // Scan flush with alternating 0,1,0,1...
        se = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            ScanChainIN = ((k - 1) % 2) == 1;
            tick();
            exp_bit = (k <= 15) ? 1'b0 : (((k - 15 - 1) % 2) == 1);
            check($sformatf("flush_e%0d", k), {15'd0, ScanChainOut}, {15'd0, exp_bit});
        end
        check("flush_state", {dut.sig, dut.cnt}, 16'h5555);

        // Reset asserted between edges while chain holds data
        #3 CoreIN_RESET = 1'b1;
        #1;
        check("async_clear_out", {15'd0, ScanChainOut}, 16'd0);
        check("async_clear_state", {dut.sig, dut.cnt}, 16'h0000);
        se = 1'b1; ScanChainIN = 1'b1;
        tick(); tick();
        check("rst_hold_se1", {dut.sig, dut.cnt}, 16'h0000);
        se = 1'b0;
        tick(); tick();
        check("rst_hold_se0", {dut.sig, dut.cnt}, 16'h0000);
        check("rst_hold_out", {15'd0, ScanChainOut}, 16'd0);
        CoreIN_RESET = 1'b0;
        ScanChainIN = 1'b0;

        // Functional count for 4 edges
        se = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("func_sig_e%0d", k + 1), {8'h00, dut.sig}, {8'h00, sig_steps[k]});
        end
        check("func_cnt", {8'h00, dut.cnt}, 16'h0004);

        // Unload: chain = {sig=03, cnt=04}, MSB first
        unload_exp = 16'h0304;
        se = 1'b1; ScanChainIN = 1'b0;
        check("unload_pre", {15'd0, ScanChainOut}, {15'd0, unload_exp[15]});
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_bit = (k < 16) ? unload_exp[15 - k] : 1'b0;
            check($sformatf("unload_e%0d", k), {15'd0, ScanChainOut}, {15'd0, exp_bit});
        end
        check("unload_chain", {dut.sig, dut.cnt}, 16'h0000);

        // Load {sig=00, cnt=FF} then one functional edge
        load_val = 16'h00FF;
        se = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            ScanChainIN = load_val[k];
            tick();
        end
        check("load_chain", {dut.sig, dut.cnt}, 16'h00FF);
        se = 1'b0; ScanChainIN = 1'b0;
        tick();
        check("run_wrap_cnt", {8'h00, dut.cnt}, 16'h0000);
        check("run_sig", {8'h00, dut.sig}, 16'h00FF);
        check("run_out", {15'd0, ScanChainOut}, 16'd1);

        // Reset mid-shift: 5 ones, reset, then 16 zeros
        CoreIN_RESET = 1'b1;
        #1 CoreIN_RESET = 1'b0;
        se = 1'b1; ScanChainIN = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("midshift_pre", {8'h00, dut.cnt}, 16'h001F);
        #2 CoreIN_RESET = 1'b1;
        #1;
        check("midshift_clear", {dut.sig, dut.cnt}, 16'h0000);
        #1 CoreIN_RESET = 1'b0;
        ScanChainIN = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("midshift_e%0d", k), {15'd0, ScanChainOut}, 16'd0);
        end
        check("midshift_chain", {dut.sig, dut.cnt}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdr.md
Name: cdr

Overview:
- Scan-testable core data register (CDR) for use inside an IEEE 1500-style core wrapper.
- Contains a free-running counter and a signature register. Both are built from flops that are stitched into one serial scan chain.
- When se=0 the core runs in functional mode: the counter counts and the signature register compacts the count.
- When se=1 the whole state shifts serially from ScanChainIN to ScanChainOut, so the wrapper can load and unload it.

Parameters:
- WIDTH, 8, bit width of the counter register and of the signature register. Total chain length is 2*WIDTH.
- TAPS, 8'hB8, feedback tap mask for the signature register. Its width is WIDTH, and bit i set means sig[i] feeds the XOR.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- CoreIN_RESET  input  1  asynchronous, active-high reset. It clears all state immediately and overrides se.
- se  input  1  scan enable. 1 = shift mode, 0 = functional mode.
- ScanChainIN  input  1  serial scan data in; enters at cnt[0].
- ScanChainOut  output  1  serial scan data out; driven directly from flop sig[WIDTH-1], with no combinational path from inputs.

Behaviour:
- State: cnt[WIDTH-1:0] and sig[WIDTH-1:0]. Chain vector chain = {sig, cnt}, 2*WIDTH bits.
- Reset:
  - While CoreIN_RESET=1, cnt=0 and sig=0, independent of CLK.
  - Therefore ScanChainOut=0 during reset.
  - Deassertion takes effect at the next rising edge of CLK.
- Reset asserted mid-shift or mid-count: state clears at once and partial shift data is lost.
- Shift mode (se=1, no reset), per rising edge:
  - chain <= {chain[2W-2:0], ScanChainIN}.
  - That is: cnt[0] <= ScanChainIN; cnt[i] <= cnt[i-1]; sig[0] <= cnt[W-1]; sig[i] <= sig[i-1].
  - The counter and signature logic are frozen.
- Scan latency: a bit applied at edge k first appears on ScanChainOut after edge k+2*WIDTH-1 (the 16th capture edge for W=8).
- Unload order: sig[W-1] first, down to sig[0], then cnt[W-1] down to cnt[0].
- Functional mode (se=0, no reset), per rising edge, both updates use pre-edge values:
  - cnt <= cnt + 1, modulo 2^WIDTH; 8'hFF wraps to 8'h00.
  - fb = XOR-reduce(sig & TAPS).
  - sig <= {sig[W-2:0], fb} ^ cnt.
- se changes take effect at the next rising edge; there are no mode-switch bubbles or extra cycles.
- se is sampled synchronously. se and ScanChainIN must meet setup/hold to CLK.
- X/Z on ScanChainIN during shift propagates as data; no special handling.

Test Plan:
- Reset: assert CoreIN_RESET=1 asynchronously between clock edges.
  - Required: ScanChainOut=0 immediately, cnt=0, sig=0.
  - Holds across edges while reset is high, for both se=0 and se=1.
- Scan flush (W=8, se=1): after reset, drive the alternating pattern 0,1,0,1… with one bit per edge.
  - Required: ScanChainOut=0 for the first 15 edges.
  - From the 16th edge onward it reproduces the input stream delayed by 16 edges.
- Functional count: reset, then se=0 for 4 edges.
  - Required: cnt=8'h04 and sig=8'h03.
  - Intermediate sig values after edges 1..4 are 00, 01, 00, 03.
- Unload after functional run: from the previous state, set se=1 and shift 16 edges with ScanChainIN=0.
  - ScanChainOut shows 0 before the first shift edge (sig[7]).
  - Values after edges 1..15 are 0,0,0,0,0,1,1,0,0,0,0,0,1,0,0. Together with the pre-shift value this is the 16-bit sequence sig then cnt.
  - After the 16th edge ScanChainOut=0 and the whole chain is 0.
- Load then run: shift in chain={sig=8'h00, cnt=8'hFF} (16 edges, ScanChainIN driven MSB of sig first), then se=0 for 1 edge.
  - Required: cnt wraps to 8'h00 and sig=8'hFF.
- Reset mid-shift: assert reset after 5 shift edges, deassert, then shift 16 zeros.
  - Required: ScanChainOut stays 0 throughout; no residue of the pre-reset data.
